// File: rtl/weight_psum_skew_buffer.sv
// Ping-pong weight bank with 45-degree output skew and psum skew lines.
// Fill: wr_valid/wr_ready rows; drain: issue_start/busy; test_mode bypass.
module weight_psum_skew_buffer #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH =
    WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   test_mode,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0]  weight_in_bisr_flat,
  input  logic                                   issue_start,
  output logic                                   busy,
  output logic [1:0]                             bank_full,
  input  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0]  weight_in_test_flat,
  input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] partial_sum_in_test_flat,
  input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] partial_sum_in_outside_flat,
  input  logic [SYSTOLIC_SIZE-1:0]               pe_disable_in,
  output logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0]  weight_out_flat,
  output logic [SYSTOLIC_SIZE-1:0]               weight_valid_out,
  output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] partial_sum_out_flat,
  output logic [SYSTOLIC_SIZE-1:0]               pe_disable_out
);

  localparam int N    = SYSTOLIC_SIZE;
  localparam int W    = WEIGHT_WIDTH;
  localparam int P    = PARTIAL_SUM_WIDTH;
  localparam int LW   = $clog2(N);
  localparam int CW   = $clog2(2*N-1);
  localparam int CMAX = 2*N-2;

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_c, w_c_nx;
  logic            w_done;
  logic            w_wr;
  logic            w_last_row;
  logic [1:0]      r_bank_full, w_full_nx;
  logic            r_fill_sel, r_drain_sel;
  logic [LW-1:0]   r_row_cnt;
  logic [N*W-1:0]  r_bank [2][N];
  logic [N*W-1:0]  r_wout, w_wout;
  logic [N-1:0]    r_wvld, w_wvld;
  logic [N*P-1:0]  w_psum_dl;

  assign wr_ready   = !test_mode && !r_bank_full[r_fill_sel];
  assign w_wr       = wr_valid && wr_ready;
  assign w_last_row = (r_row_cnt == LW'(N-1));
  assign busy       = (r_state == S_DRAIN);
  assign bank_full  = r_bank_full;

  always_comb begin
    w_state_nx = r_state;
    w_c_nx     = r_c;
    w_done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (issue_start && !test_mode &&
            r_bank_full[r_drain_sel]) begin
          w_state_nx = S_DRAIN;
          w_c_nx     = '0;
        end
      end
      S_DRAIN: begin
        if (test_mode) begin
          w_state_nx = S_IDLE;
        end else if (r_c == CW'(CMAX)) begin
          w_state_nx = S_IDLE;
          w_done     = 1'b1;
        end else begin
          w_c_nx = r_c + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_c     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_c     <= w_c_nx;
    end
  end

  // Drain-end clear and fill-complete set always hit different banks.
  always_comb begin
    w_full_nx = r_bank_full;
    if (w_done)
      w_full_nx[r_drain_sel] = 1'b0;
    if (w_wr && w_last_row)
      w_full_nx[r_fill_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_full <= '0;
      r_fill_sel  <= 1'b0;
      r_drain_sel <= 1'b0;
      r_row_cnt   <= '0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < N; r++)
          r_bank[b][r] <= '0;
    end else begin
      r_bank_full <= w_full_nx;
      if (w_done)
        r_drain_sel <= ~r_drain_sel;
      if (w_wr) begin
        r_bank[r_fill_sel][r_row_cnt] <= weight_in_bisr_flat;
        if (w_last_row) begin
          r_row_cnt  <= '0;
          r_fill_sel <= ~r_fill_sel;
        end else begin
          r_row_cnt <= r_row_cnt + LW'(1);
        end
      end
    end
  end

  // Lane j carries row c-j while that row index is in range.
  always_comb begin
    w_wout = '0;
    w_wvld = '0;
    for (int j = 0; j < N; j++)
      for (int r = 0; r < N; r++)
        if (int'(r_c) == r + j) begin
          w_wvld[j]        = 1'b1;
          w_wout[j*W +: W] = r_bank[r_drain_sel][r][j*W +: W];
        end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wout <= '0;
      r_wvld <= '0;
    end else if (r_state == S_DRAIN && !test_mode) begin
      r_wout <= w_wout;
      r_wvld <= w_wvld;
    end else begin
      r_wout <= '0;
      r_wvld <= '0;
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_lane
    logic [P-1:0] r_dl [0:j];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= j; k++)
          r_dl[k] <= '0;
      end else if (test_mode) begin
        for (int k = 0; k <= j; k++)
          r_dl[k] <= '0;
      end else begin
        r_dl[0] <= partial_sum_in_outside_flat[j*P +: P];
        for (int k = 1; k <= j; k++)
          r_dl[k] <= r_dl[k-1];
      end
    end
    assign w_psum_dl[j*P +: P] = r_dl[j];
  end

  assign weight_out_flat  = test_mode ? weight_in_test_flat : r_wout;
  assign weight_valid_out = test_mode ? '1 : r_wvld;
  assign partial_sum_out_flat =
    test_mode ? partial_sum_in_test_flat : w_psum_dl;
  assign pe_disable_out   = test_mode ? '0 : pe_disable_in;

endmodule

// File: tb/tb_weight_psum_skew_buffer.sv
// Scoreboard bench for weight_psum_skew_buffer at N=4, W=8.
// Stimulus pushes timed expectations; a negedge monitor pops them.
module tb_weight_psum_skew_buffer;

  localparam int N = 4;
  localparam int W = 8;
  localparam int A = 8;
  localparam int P = 18;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           test_mode;
  logic           wr_valid;
  logic           wr_ready;
  logic [N*W-1:0] weight_in_bisr_flat;
  logic           issue_start;
  logic           busy;
  logic [1:0]     bank_full;
  logic [N*W-1:0] weight_in_test_flat;
  logic [N*P-1:0] partial_sum_in_test_flat;
  logic [N*P-1:0] partial_sum_in_outside_flat;
  logic [N-1:0]   pe_disable_in;
  logic [N*W-1:0] weight_out_flat;
  logic [N-1:0]   weight_valid_out;
  logic [N*P-1:0] partial_sum_out_flat;
  logic [N-1:0]   pe_disable_out;

  weight_psum_skew_buffer #(
    .SYSTOLIC_SIZE(N),
    .WEIGHT_WIDTH(W),
    .ACTIVATION_WIDTH(A),
    .PARTIAL_SUM_WIDTH(P)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .test_mode(test_mode),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .weight_in_bisr_flat(weight_in_bisr_flat),
    .issue_start(issue_start),
    .busy(busy),
    .bank_full(bank_full),
    .weight_in_test_flat(weight_in_test_flat),
    .partial_sum_in_test_flat(partial_sum_in_test_flat),
    .partial_sum_in_outside_flat(partial_sum_in_outside_flat),
    .pe_disable_in(pe_disable_in),
    .weight_out_flat(weight_out_flat),
    .weight_valid_out(weight_valid_out),
    .partial_sum_out_flat(partial_sum_out_flat),
    .pe_disable_out(pe_disable_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             cyc;
    logic [N-1:0]   v;
    logic [N*W-1:0] w;
  } wexp_t;

  typedef struct {
    int           cyc;
    int           lane;
    logic [P-1:0] val;
  } pexp_t;

  wexp_t wq[$];
  pexp_t pq[$];
  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [W-1:0] rv(input int r, input int j);
    return W'(4*r + j + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int r);
    for (int j = 0; j < N; j++)
      weight_in_bisr_flat[j*W +: W] = rv(r, j);
  endtask

  task automatic write_row(input int r);
    chk($sformatf("wr_ready_row%0d", r), 128'(wr_ready), 128'(1));
    set_row(r);
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  // Pushes the first nk skewed output cycles for rows base..base+3.
  task automatic issue(input int base, input int nk);
    wexp_t e;
    int e0;
    e0 = cyc;
    for (int k = 0; k < nk; k++) begin
      e.cyc = e0 + 2 + k;
      e.v   = '0;
      e.w   = '0;
      for (int j = 0; j < N; j++)
        if (k >= j && k <= j + N - 1) begin
          e.v[j]         = 1'b1;
          e.w[j*W +: W]  = rv(base + k - j, j);
        end
      wq.push_back(e);
    end
    issue_start = 1'b1;
    tick();
    issue_start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) tick();
    chk("drain_timeout", 128'(busy), 128'(0));
  endtask

  always @(negedge clk) begin
    if (!test_mode) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        n_chk++;
        $display("FAIL w_missed: cyc %0d got none expected cyc %0d",
                 cyc, wq[0].cyc);
        void'(wq.pop_front());
      end
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        chk($sformatf("w_valid_c%0d", cyc),
            128'(weight_valid_out), 128'(wq[0].v));
        chk($sformatf("w_data_c%0d", cyc),
            128'(weight_out_flat), 128'(wq[0].w));
        void'(wq.pop_front());
      end else if (weight_valid_out != '0) begin
        n_chk++;
        $display("FAIL w_unexpected: cyc %0d got %0h expected 0",
                 cyc, weight_valid_out);
      end
      for (int i = pq.size() - 1; i >= 0; i--) begin
        if (pq[i].cyc == cyc) begin
          chk($sformatf("psum_l%0d_c%0d", pq[i].lane, cyc),
              128'(partial_sum_out_flat[pq[i].lane*P +: P]),
              128'(pq[i].val));
          pq.delete(i);
        end else if (pq[i].cyc < cyc) begin
          n_chk++;
          $display("FAIL psum_missed: lane %0d got none expected cyc %0d",
                   pq[i].lane, pq[i].cyc);
          pq.delete(i);
        end
      end
    end
  end

  initial begin
    pexp_t pe;
    int e0;
    rst_n = 1'b0;
    test_mode = 1'b0;
    wr_valid = 1'b0;
    issue_start = 1'b0;
    weight_in_bisr_flat = '0;
    weight_in_test_flat = '0;
    partial_sum_in_test_flat = '0;
    partial_sum_in_outside_flat = '0;
    pe_disable_in = '0;
    tick();
    tick();
    chk("rst_bank_full", 128'(bank_full), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_wout", 128'(weight_out_flat), 128'(0));
    chk("rst_wvld", 128'(weight_valid_out), 128'(0));
    chk("rst_psum", 128'(partial_sum_out_flat), 128'(0));
    rst_n = 1'b1;
    tick();
    chk("rst_wr_ready", 128'(wr_ready), 128'(1));

    // 1: one bank, skewed drain
    for (int r = 0; r < 4; r++) write_row(r);
    chk("t1_full", 128'(bank_full), 128'(2'b01));
    issue(0, 7);
    chk("t1_busy", 128'(busy), 128'(1));
    wait_idle();
    chk("t1_full_clr", 128'(bank_full), 128'(0));

    // 2: both banks full, drain in write order
    for (int r = 4; r < 12; r++) write_row(r);
    chk("t2_full", 128'(bank_full), 128'(2'b11));
    chk("t2_wr_ready", 128'(wr_ready), 128'(0));
    set_row(99);
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    issue(4, 7);
    wait_idle();
    chk("t2_wr_ready_back", 128'(wr_ready), 128'(1));
    chk("t2_full_mid", 128'(bank_full), 128'(2'b01));
    issue(8, 7);
    wait_idle();
    chk("t2_full_end", 128'(bank_full), 128'(0));

    // 4: psum skew, lane j lands j+1 cycles later
    e0 = cyc;
    for (int j = 0; j < N; j++) begin
      partial_sum_in_outside_flat[j*P +: P] = P'(32'h100 + j);
      for (int d = 0; d < 3; d++) begin
        pe.cyc  = e0 + j + d;
        pe.lane = j;
        pe.val  = (d == 1) ? P'(32'h100 + j) : '0;
        pq.push_back(pe);
      end
    end
    tick();
    partial_sum_in_outside_flat = '0;
    for (int i = 0; i < 6; i++) tick();

    // 3: test mode aborts a drain at c=3
    for (int r = 12; r < 16; r++) write_row(r);
    issue(12, 2);
    tick();
    tick();
    tick();
    test_mode = 1'b1;
    weight_in_test_flat = 32'hA1B2C3D4;
    partial_sum_in_test_flat = 72'h12_3456_789A_BCDE_F012;
    partial_sum_in_outside_flat = '1;
    pe_disable_in = 4'b1010;
    tick();
    chk("t3_busy", 128'(busy), 128'(0));
    chk("t3_wout", 128'(weight_out_flat), 128'(32'hA1B2C3D4));
    chk("t3_psum", 128'(partial_sum_out_flat),
        128'(72'h12_3456_789A_BCDE_F012));
    chk("t3_wvld", 128'(weight_valid_out), 128'(4'hF));
    chk("t3_pedis", 128'(pe_disable_out), 128'(0));
    chk("t3_full", 128'(bank_full), 128'(2'b10));
    chk("t3_wr_ready", 128'(wr_ready), 128'(0));
    tick();
    test_mode = 1'b0;
    partial_sum_in_outside_flat = '0;
    tick();
    chk("t3_psum_clr", 128'(partial_sum_out_flat), 128'(0));
    chk("t3_pedis_norm", 128'(pe_disable_out), 128'(4'b1010));
    issue(12, 7);
    wait_idle();

    // 5: ignored issues, same-cycle fill, fill during drain
    issue_start = 1'b1;
    tick();
    issue_start = 1'b0;
    chk("t5_no_full", 128'(busy), 128'(0));
    for (int r = 16; r < 19; r++) write_row(r);
    set_row(19);
    wr_valid = 1'b1;
    issue_start = 1'b1;
    tick();
    wr_valid = 1'b0;
    issue_start = 1'b0;
    chk("t5_same_cycle", 128'(busy), 128'(0));
    chk("t5_full", 128'(bank_full), 128'(2'b01));
    issue(16, 7);
    for (int r = 20; r < 24; r++) write_row(r);
    issue_start = 1'b1;
    tick();
    issue_start = 1'b0;
    chk("t5_busy_hold", 128'(busy), 128'(1));
    wait_idle();
    chk("t5_full_other", 128'(bank_full), 128'(2'b10));
    issue(20, 7);
    wait_idle();

    // 6: reset mid-fill, then mid-drain
    write_row(24);
    write_row(25);
    rst_n = 1'b0;
    #1;
    chk("t6_fill_rst_full", 128'(bank_full), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_fill_rst_ready", 128'(wr_ready), 128'(1));
    for (int r = 24; r < 28; r++) write_row(r);
    chk("t6_full", 128'(bank_full), 128'(2'b01));
    issue(24, 1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 128'(busy), 128'(0));
    chk("t6_rst_full", 128'(bank_full), 128'(0));
    chk("t6_rst_wout", 128'(weight_out_flat), 128'(0));
    chk("t6_rst_wvld", 128'(weight_valid_out), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_rst_ready", 128'(wr_ready), 128'(1));

    tick();
    tick();
    chk("end_wq_empty", 128'(wq.size()), 128'(0));
    chk("end_pq_empty", 128'(pq.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
